// File: rtl/uart_tx_arb_if.sv
// Purpose : request/grant and uart_tx side signals of the uart_tx_arb block.
// Latency : none (wiring only).
// Backpres: req is held by a requester until its gnt pulse; tx_done ends ownership.
//
// Signals
//   req[N_REQ]          per-requester request level
//   req_data[N_REQ*DW]  byte of requester i at [i*DW +: DW]
//   gnt[N_REQ]          one-hot consume pulse
//   owner[3]            current/last winner index
//   busy                arbiter not idle
//   tx_start / tx_din   start pulse and byte to uart_tx
//   tx_done             uart_tx completion pulse
//   err_timeout         WAIT timeout pulse
// Modports: master = arbiter side, slave = requesters + uart_tx side.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic [2:0]          owner;
  logic                busy;
  logic                tx_start;
  logic [DW-1:0]       tx_din;
  logic                tx_done;
  logic                err_timeout;

  modport master (
    input  req, req_data, tx_done,
    output gnt, owner, busy, tx_start, tx_din, err_timeout
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, owner, busy, tx_start, tx_din, err_timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Purpose : round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Latency : gnt and tx_start one cycle after a winning request is seen in IDLE.
// Backpres: ownership held from START until tx_done; other requests wait in place.
//
// Ports
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    uart_tx_arb_if.master (req/req_data/tx_done in, gnt/owner/busy/
//          tx_start/tx_din/err_timeout out)
// Optional feature macro: UART_ARB_TIMEOUT_EN -- abort WAIT after TO_CYC cycles
// without tx_done and pulse err_timeout. Undefined: err_timeout is tied to 0.
module uart_tx_arb #(
  parameter int          N_REQ  = 4,
  parameter int          DW     = 8,
  parameter logic [15:0] TO_CYC = 16'd4095
) (
  input  logic         clk,
  input  logic         n_rst,
  uart_tx_arb_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  // Index following i, wrapping at N_REQ.
  function automatic logic [2:0] nxt_idx(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic [DW-1:0]    din_q, din_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             start_q, start_d;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic             unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  // Winner search: lowest requester at or above rr_ptr, else lowest overall
  // (that is the wrap-around part of the round-robin scan).
  logic          hi_vld, lo_vld, win_vld;
  logic [2:0]    hi_idx, lo_idx, win_idx;
  logic [DW-1:0] win_byte;

  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    // Descending scan so the last hit is the lowest index.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_vld = 1'b1;
        lo_idx = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;

    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == win_idx) begin
        win_byte = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    din_d    = din_q;
    gnt_d    = '0;
    start_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // While a zero-byte gnt is visible the requester still shows req;
        // skipping arbitration for that cycle prevents a double grant.
        if (win_vld && (gnt_q == '0)) begin
          gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          if (win_byte != '0) begin
            state_d = S_START;
            owner_d = win_idx;
            din_d   = win_byte;
            start_d = 1'b1;
          end else begin
            // uart_tx would ignore a zero byte: consume it without a transfer.
            rr_ptr_d = nxt_idx(win_idx);
          end
        end
      end

      S_START: begin
        state_d = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_WAIT: begin
        if (bus.tx_done) begin
          state_d  = S_IDLE;
          rr_ptr_d = nxt_idx(owner_q);
`ifdef UART_ARB_TIMEOUT_EN
        // cnt_q is the number of WAIT cycles already spent; this cycle
        // brings it to TO_CYC, and tx_done (checked first) wins a tie.
        end else if (cnt_q == TO_CYC - 16'd1) begin
          state_d  = S_IDLE;
          rr_ptr_d = nxt_idx(owner_q);
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      din_q    <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      din_q    <= din_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_start = start_q;
  assign bus.tx_din   = din_q;

endmodule
